// File: rtl/ic74138_decoder_sync_if.sv
// Decoder bus: enable/select toward the decoder, registered decode and status back.
interface ic74138_decoder_sync_if #(
    parameter int unsigned CNT_W = 8
);
    logic [2:0]       I;
    logic [2:0]       S;
    logic [7:0]       D;
    logic [7:0]       D_oh;
    logic             en;
    logic [CNT_W-1:0] en_cnt;

    modport master (
        output I, S,
        input  D, D_oh, en, en_cnt
    );

    modport slave (
        input  I, S,
        output D, D_oh, en, en_cnt
    );
endinterface

// File: rtl/ic74138_decoder_sync.sv
// Registered 74138-style 3-to-8 decoder with one-hot copy, enable flag and a
// saturating count of enabled cycles.
module ic74138_decoder_sync #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ic74138_decoder_sync_if.slave  bus
);
    localparam int unsigned OUT_W = 8;

    logic             enabled;
    logic [OUT_W-1:0] d_next;
    logic             cnt_sat;

    // G1 high with both G2 strobes low is the only enabling combination.
    always_comb begin
        enabled = 1'b0;
        d_next  = '1;
        enabled = bus.I[2] & ~bus.I[1] & ~bus.I[0];
        if (enabled) begin
            d_next = ~(OUT_W'(1) << bus.S);
        end
    end

    assign cnt_sat = &bus.en_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.D      <= '1;
            bus.D_oh   <= '0;
            bus.en     <= 1'b0;
            bus.en_cnt <= '0;
        end else begin
            bus.D    <= d_next;
            bus.D_oh <= ~d_next;
            bus.en   <= enabled;
            if (enabled && !cnt_sat) begin
                bus.en_cnt <= bus.en_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ic74138_decoder_sync.sv
// Self-checking bench: vector table plus hand sequences, scoreboard of expected outputs.
module tb_ic74138_decoder_sync;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ic74138_decoder_sync_if #(.CNT_W(8)) bus ();
    ic74138_decoder_sync_if #(.CNT_W(3)) bus3 ();

    assign bus3.I = bus.I;
    assign bus3.S = bus.S;

    ic74138_decoder_sync #(.CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ic74138_decoder_sync #(.CNT_W(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        logic [2:0] i;
        logic [2:0] s;
        logic [7:0] d;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic [7:0] cnt;
        logic [2:0] cnt3;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   tests  = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    int   m_cnt3 = 0;

    logic [7:0] en_d [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [2:0] dis_i [3] = '{3'b011, 3'b101, 3'b010};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_D"},      bus.D, 8'hFF);
        check({tag, "_D_oh"},   bus.D_oh, 8'h00);
        check({tag, "_en"},     8'(bus.en), 8'h00);
        check({tag, "_en_cnt"}, bus.en_cnt, 8'h00);
        check({tag, "_cnt3"},   8'(bus3.en_cnt), 8'h00);
    endtask

    task automatic collect();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("D",      bus.D, e.d);
            check("D_oh",   bus.D_oh, ~e.d);
            check("en",     8'(bus.en), 8'(e.en));
            check("en_cnt", bus.en_cnt, e.cnt);
            check("cnt3",   8'(bus3.en_cnt), 8'(e.cnt3));
        end
    endtask

    // Drive one input pair at the falling edge, predict, then compare after the rising edge.
    task automatic drive(input logic [2:0] i, input logic [2:0] s, input logic [7:0] d_exp,
                         input bit rel = 1'b0);
        exp_t e;
        logic en_exp;
        @(negedge clk);
        if (rel) rst = 1'b0;
        bus.I  = i;
        bus.S  = s;
        en_exp = (i == 3'b100);
        if (en_exp && m_cnt < 255) m_cnt++;
        if (en_exp && m_cnt3 < 7) m_cnt3++;
        e.d    = d_exp;
        e.en   = en_exp;
        e.cnt  = 8'(m_cnt);
        e.cnt3 = 3'(m_cnt3);
        sb.push_back(e);
        @(posedge clk);
        #1;
        collect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst   = 1'b1;
        bus.I = 3'b000;
        bus.S = 3'b000;
        #1;
        check_reset_state("por");
        repeat (2) @(negedge clk);
        check_reset_state("por_hold");
        drive(3'b000, 3'd0, 8'hFF, 1'b1);

        // Enabled sweep
        for (int k = 0; k < 8; k++) begin
            v.i = 3'b100; v.s = 3'(k); v.d = en_d[k]; vecs.push_back(v);
        end
        // Disabled sweeps
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 8; k++) begin
                v.i = dis_i[j]; v.s = 3'(k); v.d = 8'hFF; vecs.push_back(v);
            end
        end
        // All enable codes with S=5
        for (int k = 0; k < 8; k++) begin
            v.i = 3'(k); v.s = 3'd5; v.d = (k == 4) ? 8'hDF : 8'hFF; vecs.push_back(v);
        end
        // Enable toggling with S=3
        for (int k = 0; k < 8; k++) begin
            v.i = (k % 2 == 0) ? 3'b100 : 3'b000; v.s = 3'd3;
            v.d = (k % 2 == 0) ? 8'hF7 : 8'hFF; vecs.push_back(v);
        end
        // Simultaneous I and S change
        v.i = 3'b100; v.s = 3'd7; v.d = 8'h7F; vecs.push_back(v);
        v.i = 3'b111; v.s = 3'd0; v.d = 8'hFF; vecs.push_back(v);
        v.i = 3'b100; v.s = 3'd0; v.d = 8'hFE; vecs.push_back(v);

        foreach (vecs[n]) drive(vecs[n].i, vecs[n].s, vecs[n].d);

        // Asynchronous reset in mid-run, checked before the next clock edge
        drive(3'b100, 3'd2, 8'hFB);
        drive(3'b100, 3'd2, 8'hFB);
        @(posedge clk);
        #2;
        sb.delete();
        rst = 1'b1;
        #1;
        check_reset_state("mid_async");
        m_cnt  = 0;
        m_cnt3 = 0;
        @(posedge clk);
        #1;
        check_reset_state("mid_hold");
        drive(3'b100, 3'd2, 8'hFB, 1'b1);

        // Saturation of the narrow counter
        for (int k = 0; k < 10; k++) drive(3'b100, 3'd7, 8'h7F);
        check("cnt3_saturated", 8'(bus3.en_cnt), 8'd7);
        check("cnt_after_sat",  bus.en_cnt, 8'd11);

        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/ic74138_decoder_sync.md
Name: ic74138_decoder_sync

Overview:
Registered 3-to-8 line decoder modelled on the 74138: three enable inputs, one 3-bit select and eight active-low outputs. It is used as a chip-select or strobe generator in synchronous logic. All outputs are registered on one clock. The block also exposes an active-high one-hot copy of the decode, an enable status bit and a saturating count of enabled cycles.

Parameters:
CNT_W, 8, width of the enabled-cycle counter (minimum 1).

Ports:
clk  input  1  system clock; all registers update on its rising edge.
rst  input  1  asynchronous, active-high reset.
I  input  3  enable bundle: I[2]=G1 (active high), I[1]=G2B_n (active low), I[0]=G2A_n (active low).
S  input  3  select code; S[2] is MSB (C), S[0] is LSB (A).
D  output  8  registered active-low decoder outputs; D[k] is Yk_n.
D_oh  output  8  registered active-high one-hot decode; always equal to ~D.
en  output  1  registered enable status: 1 when the captured I equals 3'b100.
en_cnt  output  CNT_W  count of rising edges on which the decoder was enabled; saturates.

Behaviour:
- Enable condition: enabled = I[2] & ~I[1] & ~I[0], i.e. I == 3'b100 only. Every other I value (0-3, 5-7) disables the decoder.
- Next-state decode:
  - enabled: D_next = ~(8'b1 << S), so exactly bit S is 0.
  - disabled: D_next = 8'hFF, independent of S.
- At each rising clk edge with rst low:
  - D <= D_next
  - D_oh <= ~D_next
  - en <= enabled
  - if enabled and en_cnt != all-ones, en_cnt <= en_cnt + 1; otherwise en_cnt holds.
- Latency: exactly one clock from I/S to D, D_oh and en. There is no combinational input-to-output path.
- Reset: while rst is high, regardless of clk:
  - D = 8'hFF
  - D_oh = 8'h00
  - en = 0
  - en_cnt = 0
- Reset mid-operation: all outputs clear immediately. The first edge after rst deasserts loads the decode of the current inputs.
- Invariants, every cycle:
  - D_oh == ~D.
  - At most one bit of D is 0, and exactly one when en = 1.
  - en = 0 implies D = 8'hFF.
- Boundary cases:
  - S = 0 gives D = 8'hFE; S = 7 gives D = 8'h7F.
  - en_cnt sticks at 2^CNT_W-1 and does not wrap.
  - Simultaneous changes of I and S are decoded together on the next edge.
- X or Z on I or S is not handled specially; behaviour follows ordinary RTL semantics.

Test Plan:
1. Reset: assert rst mid-run with I=3'b100, S=2 -> D=8'hFF, D_oh=8'h00, en=0, en_cnt=0 asynchronously, before the next clk edge. Release rst -> the next edge gives D=8'hFB.
2. Enabled sweep: I=3'b100, S stepped 0..7 one per clock -> one cycle after each step D = FE, FD, FB, F7, EF, DF, BF, 7F. D_oh = ~D, en=1, and en_cnt rises by 1 per edge.
3. Disabled sweeps: for each of I = 3'b011, 3'b101, 3'b010, sweep S through 0..7 -> D=8'hFF, D_oh=8'h00 and en=0 on every cycle. en_cnt does not change.
4. Full enable decode: all 8 I values with S=5 -> D=8'hDF only for I=3'b100; 8'hFF for the other seven values.
5. Enable toggling: I alternates 3'b100 / 3'b000 every cycle with S=3 -> D alternates F7/FF with one-clock latency. en_cnt increments only on the enabled edges.
6. Saturation with CNT_W=3: hold enabled for 10 clocks -> en_cnt reaches 7 and stays at 7.
